// File: rtl/memory_pkg.sv
// Shared definitions for the dual-port memory: sweep FSM states and the
// read-latency / collision mode encodings.
package memory_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int LAT_SINGLE = 1;
    localparam int LAT_DOUBLE = 2;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

endpackage

// File: rtl/mem_read_pipe.sv
// Output stage for one read port: turns a raw word plus accept strobe into a
// held DOut and a one-edge Valid, with an optional extra pipeline register.
module mem_read_pipe
    import memory_pkg::*;
#(
    parameter int DataWidth   = 16,
    parameter int ReadLatency = LAT_SINGLE
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic                 i_accept,
    input  logic [DataWidth-1:0] i_word,
    output logic [DataWidth-1:0] o_dout,
    output logic                 o_valid
);

    logic                 w_stage_valid;
    logic [DataWidth-1:0] w_stage_word;
    logic                 r_valid;
    logic [DataWidth-1:0] r_dout;

    if (ReadLatency == LAT_DOUBLE) begin : g_stage
        logic                 r_s1_valid;
        logic [DataWidth-1:0] r_s1_word;

        // Reset clears the in-flight flag so flushed reads never raise Valid.
        always_ff @(negedge Clk or negedge Reset_N) begin
            if (!Reset_N) begin
                r_s1_valid <= 1'b0;
                r_s1_word  <= '0;
            end else begin
                r_s1_valid <= i_accept;
                if (i_accept) r_s1_word <= i_word;
            end
        end

        assign w_stage_valid = r_s1_valid;
        assign w_stage_word  = r_s1_word;
    end else begin : g_direct
        assign w_stage_valid = i_accept;
        assign w_stage_word  = i_word;
    end

    always_ff @(negedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_valid <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_valid <= w_stage_valid;
            if (w_stage_valid) r_dout <= w_stage_word;
        end
    end

    assign o_dout  = r_dout;
    assign o_valid = r_valid;

endmodule

// File: rtl/memory_dp.sv
// Dual-port memory: port A read/write with byte lanes, port B read-only,
// collision handling and an optional post-reset clear sweep.
module memory_dp
    import memory_pkg::*;
#(
    parameter int                  AddrWidth       = 8,
    parameter int                  DataWidth       = 16,
    parameter int                  ReadLatency     = LAT_SINGLE,
    parameter int                  ReadDuringWrite = RDW_OLD,
    parameter int                  ClearOnReset    = 0,
    parameter logic [DataWidth-1:0] ClearValue     = '0,
    parameter string               InitFile        = ""
) (
    input  logic                   Clk,
    input  logic                   Reset_N,
    input  logic                   A_En,
    input  logic                   A_Write_EN,
    input  logic [DataWidth/8-1:0] A_ByteEn_N,
    input  logic [AddrWidth-1:0]   A_Address,
    input  logic [DataWidth-1:0]   A_DIn,
    output logic [DataWidth-1:0]   A_DOut,
    output logic                   A_Valid,
    input  logic                   B_En,
    input  logic [AddrWidth-1:0]   B_Address,
    output logic [DataWidth-1:0]   B_DOut,
    output logic                   B_Valid,
    output logic                   Busy
);

    localparam int                   NumLanes = DataWidth / 8;
    localparam int                   Depth    = 1 << AddrWidth;
    localparam logic [AddrWidth-1:0] LastAddr = '1;

    if (DataWidth % 8 != 0) begin : g_bad_width
        $error("memory_dp: DataWidth must be a multiple of 8");
    end
    if (ReadLatency != LAT_SINGLE && ReadLatency != LAT_DOUBLE) begin : g_bad_latency
        $error("memory_dp: ReadLatency must be 1 or 2");
    end
    if (ClearOnReset != 0 && InitFile != "") begin : g_init_ignored
        $warning("memory_dp: InitFile is ignored when ClearOnReset = 1");
    end

    state_t               r_state;
    state_t               w_state_next;
    logic [AddrWidth-1:0] r_cnt;
    logic [AddrWidth-1:0] w_cnt_next;
    logic [DataWidth-1:0] r_mem [Depth];

    logic                 w_busy;
    logic                 w_a_write;
    logic                 w_a_read;
    logic                 w_b_read;
    logic                 w_collide;
    logic [DataWidth-1:0] w_a_old;
    logic [DataWidth-1:0] w_b_old;
    logic [DataWidth-1:0] w_a_merged;
    logic [DataWidth-1:0] w_b_word;

    always_ff @(negedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            if (ClearOnReset != 0) r_state <= ST_CLEAR;
            else                   r_state <= ST_READY;
            r_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (r_state == ST_CLEAR) begin
            w_cnt_next = r_cnt + AddrWidth'(1);
            if (r_cnt == LastAddr) w_state_next = ST_READY;
        end
    end

    assign w_busy    = (r_state == ST_CLEAR);
    assign w_a_write = !w_busy && !A_En && !A_Write_EN;
    assign w_a_read  = !w_busy && !A_En &&  A_Write_EN;
    assign w_b_read  = !w_busy && !B_En;
    assign w_collide = w_a_write && w_b_read && (A_Address == B_Address);

    assign w_a_old = r_mem[A_Address];
    assign w_b_old = r_mem[B_Address];

    always_comb begin
        w_a_merged = w_a_old;
        for (int i = 0; i < NumLanes; i++) begin
            if (!A_ByteEn_N[i]) w_a_merged[i*8 +: 8] = A_DIn[i*8 +: 8];
        end
    end

    // Same-edge A write / B read: forward the merged word only in new-data mode.
    assign w_b_word = (ReadDuringWrite == RDW_NEW && w_collide) ? w_a_merged : w_b_old;

    // NOTE: the array has no reset branch; contents survive reset and map onto block RAM.
    always_ff @(negedge Clk) begin
        if (w_busy)         r_mem[r_cnt]     <= ClearValue;
        else if (w_a_write) r_mem[A_Address] <= w_a_merged;
    end

    mem_read_pipe #(
        .DataWidth   (DataWidth),
        .ReadLatency (ReadLatency)
    ) u_pipe_a (
        .Clk      (Clk),
        .Reset_N  (Reset_N),
        .i_accept (w_a_read),
        .i_word   (w_a_old),
        .o_dout   (A_DOut),
        .o_valid  (A_Valid)
    );

    mem_read_pipe #(
        .DataWidth   (DataWidth),
        .ReadLatency (ReadLatency)
    ) u_pipe_b (
        .Clk      (Clk),
        .Reset_N  (Reset_N),
        .i_accept (w_b_read),
        .i_word   (w_b_word),
        .o_dout   (B_DOut),
        .o_valid  (B_Valid)
    );

    assign Busy = w_busy;

endmodule

// File: tb/tb_memory_dp.sv
// Directed bench: one clear-sweep instance, plus latency-1/old-data and
// latency-2/new-data instances sharing one stimulus set.
module tb_memory_dp;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Clear-sweep instance: 16 words, ClearValue A5A5.
    logic        c_a_en, c_a_we, c_b_en;
    logic [1:0]  c_a_be;
    logic [3:0]  c_a_addr, c_b_addr;
    logic [15:0] c_a_din, c_a_dout, c_b_dout;
    logic        c_a_valid, c_b_valid, c_busy;

    // Shared stimulus for the two 256-word instances.
    logic        a_en, a_we, b_en;
    logic [1:0]  a_be;
    logic [7:0]  a_addr, b_addr;
    logic [15:0] a_din;

    logic [15:0] l1_a_dout, l1_b_dout, l2_a_dout, l2_b_dout;
    logic        l1_a_valid, l1_b_valid, l2_a_valid, l2_b_valid;
    logic        l1_busy, l2_busy;

    int n_checks = 0;
    int n_pass   = 0;

    memory_dp #(
        .AddrWidth(4), .DataWidth(16), .ReadLatency(1), .ReadDuringWrite(0),
        .ClearOnReset(1), .ClearValue(16'hA5A5)
    ) u_dut_clr (
        .Clk(clk), .Reset_N(rst_n),
        .A_En(c_a_en), .A_Write_EN(c_a_we), .A_ByteEn_N(c_a_be),
        .A_Address(c_a_addr), .A_DIn(c_a_din), .A_DOut(c_a_dout), .A_Valid(c_a_valid),
        .B_En(c_b_en), .B_Address(c_b_addr), .B_DOut(c_b_dout), .B_Valid(c_b_valid),
        .Busy(c_busy)
    );

    memory_dp #(
        .AddrWidth(8), .DataWidth(16), .ReadLatency(1), .ReadDuringWrite(0),
        .ClearOnReset(0)
    ) u_dut_l1 (
        .Clk(clk), .Reset_N(rst_n),
        .A_En(a_en), .A_Write_EN(a_we), .A_ByteEn_N(a_be),
        .A_Address(a_addr), .A_DIn(a_din), .A_DOut(l1_a_dout), .A_Valid(l1_a_valid),
        .B_En(b_en), .B_Address(b_addr), .B_DOut(l1_b_dout), .B_Valid(l1_b_valid),
        .Busy(l1_busy)
    );

    memory_dp #(
        .AddrWidth(8), .DataWidth(16), .ReadLatency(2), .ReadDuringWrite(1),
        .ClearOnReset(0)
    ) u_dut_l2 (
        .Clk(clk), .Reset_N(rst_n),
        .A_En(a_en), .A_Write_EN(a_we), .A_ByteEn_N(a_be),
        .A_Address(a_addr), .A_DIn(a_din), .A_DOut(l2_a_dout), .A_Valid(l2_a_valid),
        .B_En(b_en), .B_Address(b_addr), .B_DOut(l2_b_dout), .B_Valid(l2_b_valid),
        .Busy(l2_busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // Advance one active (falling) edge and settle before sampling or driving.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic a_write(input logic [7:0] addr, input logic [15:0] data, input logic [1:0] be_n);
        a_en = 1'b0; a_we = 1'b0; a_addr = addr; a_din = data; a_be = be_n;
    endtask

    initial begin
        rst_n  = 1'b0;
        c_a_en = 1'b1; c_a_we = 1'b1; c_a_be = 2'b11; c_a_addr = '0; c_a_din = '0;
        c_b_en = 1'b1; c_b_addr = '0;
        a_en = 1'b1; a_we = 1'b1; a_be = 2'b11; a_addr = '0; a_din = '0;
        b_en = 1'b1; b_addr = '0;
        repeat (2) tick();

        check("rst_busy_clr", c_busy, 1'b1);
        check("rst_busy_l1", l1_busy, 1'b0);
        check("rst_busy_l2", l2_busy, 1'b0);
        check("rst_dout_clr", {c_a_dout, c_b_dout}, 32'h0);
        check("rst_valid_clr", {c_a_valid, c_b_valid}, 2'b00);
        check("rst_dout_l2", {l2_a_dout, l2_b_dout}, 32'h0);
        rst_n = 1'b1;

        // Sweep length: Busy through edge 15, clear after edge 16.
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e >= 15) check($sformatf("sweep_busy_e%0d", e), c_busy, (e < 16));
        end

        for (int i = 0; i < 16; i++) begin
            c_b_en = 1'b0; c_b_addr = 4'(i);
            tick();
            check($sformatf("clear_word_%0d", i), c_b_dout, 16'hA5A5);
            check($sformatf("clear_valid_%0d", i), c_b_valid, 1'b1);
        end
        c_b_en = 1'b1;
        tick();
        check("b_valid_drop", c_b_valid, 1'b0);
        check("b_dout_hold", c_b_dout, 16'hA5A5);

        c_a_en = 1'b0; c_a_we = 1'b0; c_a_be = 2'b00; c_a_addr = 4'd2; c_a_din = 16'h0F0F;
        tick();
        check("clr_write_no_valid", c_a_valid, 1'b0);
        c_a_we = 1'b1;
        tick();
        c_a_en = 1'b1;
        check("clr_a_read", c_a_dout, 16'h0F0F);
        check("clr_a_valid", c_a_valid, 1'b1);

        // Reset with live outputs, then again mid-sweep at cnt = 7.
        rst_n = 1'b0;
        #2;
        check("rst2_dout", {c_a_dout, c_b_dout}, 32'h0);
        check("rst2_valid", {c_a_valid, c_b_valid}, 2'b00);
        check("rst2_busy", c_busy, 1'b1);
        rst_n = 1'b1;
        repeat (7) tick();
        rst_n = 1'b0;
        #2;
        check("rst3_busy", c_busy, 1'b1);
        rst_n = 1'b1;

        // Requests while Busy must be dropped entirely.
        c_a_en = 1'b0; c_a_we = 1'b0; c_a_be = 2'b00; c_a_addr = 4'd0; c_a_din = 16'h5A5A;
        c_b_en = 1'b0; c_b_addr = 4'd4;
        for (int e = 1; e <= 16; e++) begin
            tick();
            check($sformatf("busy_no_valid_e%0d", e), {c_a_valid, c_b_valid}, 2'b00);
            if (e >= 15) check($sformatf("resweep_busy_e%0d", e), c_busy, (e < 16));
        end
        check("busy_a_dout_held", c_a_dout, 16'h0000);
        c_a_we = 1'b1; c_a_addr = 4'd0; c_b_addr = 4'd7;
        tick();
        c_a_en = 1'b1; c_b_en = 1'b1;
        check("busy_write_dropped", c_a_dout, 16'hA5A5);
        check("resweep_word7", c_b_dout, 16'hA5A5);

        // Byte-lane merge: FFFF then 1234 with only lane 0 enabled.
        a_write(8'h10, 16'hFFFF, 2'b00);
        tick();
        a_write(8'h10, 16'h1234, 2'b10);
        tick();
        check("write_no_valid_l1", l1_a_valid, 1'b0);
        check("write_no_dout_l1", l1_a_dout, 16'h0000);
        a_we = 1'b1;
        tick();
        a_en = 1'b1;
        check("merge_l1_dout", l1_a_dout, 16'hFF34);
        check("merge_l1_valid", l1_a_valid, 1'b1);
        check("merge_l2_early", l2_a_valid, 1'b0);
        tick();
        check("merge_l1_valid_drop", l1_a_valid, 1'b0);
        check("merge_l1_hold", l1_a_dout, 16'hFF34);
        check("merge_l2_dout", l2_a_dout, 16'hFF34);
        check("merge_l2_valid", l2_a_valid, 1'b1);
        tick();
        check("merge_l2_valid_drop", l2_a_valid, 1'b0);

        // Collisions on 0x20: full-word then upper-lane-only write.
        a_write(8'h20, 16'h0000, 2'b00);
        b_en = 1'b0; b_addr = 8'h10;
        tick();
        a_write(8'h20, 16'hBEEF, 2'b00);
        b_addr = 8'h20;
        tick();
        check("coll_old_l1", l1_b_dout, 16'h0000);
        check("coll_old_l1_valid", l1_b_valid, 1'b1);
        check("coll_l2_prev", l2_b_dout, 16'hFF34);
        a_write(8'h20, 16'h1200, 2'b01);
        tick();
        a_en = 1'b1; b_en = 1'b1;
        check("coll2_old_l1", l1_b_dout, 16'hBEEF);
        check("coll_new_l2", l2_b_dout, 16'hBEEF);
        tick();
        check("coll2_new_l2", l2_b_dout, 16'h12EF);
        check("coll2_l2_valid", l2_b_valid, 1'b1);
        check("coll2_l1_valid_drop", l1_b_valid, 1'b0);
        a_en = 1'b0; a_we = 1'b1; a_addr = 8'h20;
        tick();
        a_en = 1'b1;
        check("coll2_stored", l1_a_dout, 16'h12EF);

        // Back-to-back B reads of 0x00..0x02.
        a_write(8'h00, 16'h0A0A, 2'b00);
        tick();
        a_write(8'h01, 16'h1B1B, 2'b00);
        tick();
        a_write(8'h02, 16'h2C2C, 2'b00);
        tick();
        a_en = 1'b1;
        b_en = 1'b0; b_addr = 8'h00;
        tick();
        check("pipe0_l1", l1_b_dout, 16'h0A0A);
        check("pipe0_l2_valid", l2_b_valid, 1'b0);
        b_addr = 8'h01;
        tick();
        check("pipe1_l1", l1_b_dout, 16'h1B1B);
        check("pipe1_l2", {l2_b_valid, l2_b_dout}, {1'b1, 16'h0A0A});
        b_addr = 8'h02;
        tick();
        b_en = 1'b1;
        check("pipe2_l1", l1_b_dout, 16'h2C2C);
        check("pipe2_l2", {l2_b_valid, l2_b_dout}, {1'b1, 16'h1B1B});
        tick();
        check("pipe3_l1_valid", l1_b_valid, 1'b0);
        check("pipe3_l2", {l2_b_valid, l2_b_dout}, {1'b1, 16'h2C2C});
        tick();
        check("pipe4_l2", {l2_b_valid, l2_b_dout}, {1'b0, 16'h2C2C});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
